// File: rtl/calc_pkg.sv
// Shared calculator types: readback FSM states, BCD conversion constants and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}); pure declarations, no timing.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam int BCD_W  = 4;
  localparam int N_ITER = 5;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern, purely combinational (0 cycles).
// Codes 10..15 blank the digit; no flow control.
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Captures a 5-bit result, converts to two BCD digits in 7 cycles, scans them onto a
// common-anode display; load ignored while busy. LEAD_ZERO_BLANK_EN blanks a zero tens digit.
module result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] value,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int WORK_W = 2 * BCD_W + N_ITER;

  state_t              r_state;
  state_t              w_state_next;
  logic [WORK_W-1:0]   r_work;
  logic [WORK_W-1:0]   w_work_next;
  logic [2:0]          r_iter;
  logic [2:0]          w_iter_next;
  logic                w_latch;
  logic [BCD_W-1:0]    r_tens;
  logic [BCD_W-1:0]    r_ones;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sel;
  logic [6:0]          r_seg;
  logic [3:0]          r_an;
  logic [BCD_W-1:0]    w_digit;
  logic [6:0]          w_dec;
  logic [6:0]          w_seg;
  logic [3:0]          w_an;

  // Working register layout: {tens, ones, remaining binary bits}.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_iter_next  = r_iter;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_work_next  = {{(2*BCD_W){1'b0}}, value};
          w_iter_next  = 3'd0;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_work_next  = {add3(r_work[WORK_W-1 -: BCD_W]),
                        add3(r_work[N_ITER +: BCD_W]),
                        r_work[N_ITER-1:0]} << 1;
        w_iter_next  = r_iter + 3'd1;
        if (r_iter == 3'(N_ITER - 1)) w_state_next = LATCH;
      end
      LATCH: begin
        w_latch      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_digit = r_sel ? r_tens : r_ones;

  seg7_decode u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg = w_dec;
    w_an  = r_sel ? 4'b1101 : 4'b1110;
`ifdef LEAD_ZERO_BLANK_EN
    if (r_sel && (r_tens == 4'd0)) begin
      w_seg = SEG_BLANK;
      w_an  = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_iter  <= 3'd0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_seg   <= SEG_BLANK;
      r_an    <= 4'b1111;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_iter  <= w_iter_next;
      r_done  <= w_latch;
      if (w_latch) begin
        r_tens <= r_work[WORK_W-1 -: BCD_W];
        r_ones <= r_work[N_ITER +: BCD_W];
      end
      // Scan phase is free-running; conversions never disturb it.
      if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_sel <= ~r_sel;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule
